// File: rtl/combo_check_param.sv
// Parametrised serial combination checker with failure counting,
// timed lockout and alarm, between keypad front end and lock driver.
module combo_check_param #(
    parameter int DIGITS      = 6,
    parameter int WIDTH       = 5,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 16,
    localparam int FW = $clog2(MAX_FAIL + 1),
    localparam int IW = $clog2(DIGITS),
    localparam int TW = $clog2(LOCKOUT_CYC + 1)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    LOAD,
    input  logic [DIGITS*WIDTH-1:0] combo_in,
    input  logic [WIDTH-1:0]        digit_in,
    input  logic                    digit_valid,
    input  logic                    clear,
    output logic                    unlocked,
    output logic                    err,
    output logic                    alarm,
    output logic [FW-1:0]           fail_cnt,
    output logic [IW-1:0]           digit_idx,
    output logic                    programmed
);

    typedef enum logic [1:0] {
        UNPROG  = 2'd0,
        ENTRY   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DIGITS*WIDTH-1:0] combo_q, combo_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           fail_q, fail_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    mis_q, mis_d;
    logic                    prog_q, prog_d;
    logic                    err_q, err_d;
    logic                    unl_q, alarm_q;

    logic [WIDTH-1:0] cur;
    logic             final_mis;
    logic             last;
    logic [FW-1:0]    fail_inc;

    // Stored code at the current entry position.
    always_comb begin
        cur = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) cur = combo_q[k*WIDTH +: WIDTH];
        end
    end

    assign final_mis = mis_q | (digit_in != cur);
    assign last      = (idx_q == IW'(DIGITS - 1));
    assign fail_inc  = fail_q + FW'(1);

    always_comb begin
        state_d = state_q;
        combo_d = combo_q;
        idx_d   = idx_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        mis_d   = mis_q;
        prog_d  = prog_q;
        err_d   = 1'b0;
        unique case (state_q)
            UNPROG: begin
                if (LOAD) begin
                    combo_d = combo_in;
                    prog_d  = 1'b1;
                    state_d = ENTRY;
                    idx_d   = '0;
                    fail_d  = '0;
                    mis_d   = 1'b0;
                end
            end
            ENTRY: begin
                if (clear) begin
                    idx_d = '0;
                    mis_d = 1'b0;
                end else if (digit_valid) begin
                    if (!last) begin
                        mis_d = final_mis;
                        idx_d = idx_q + IW'(1);
                    end else begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (!final_mis) begin
                            state_d = OPEN;
                            fail_d  = '0;
                        end else if (fail_inc < FW'(MAX_FAIL)) begin
                            fail_d = fail_inc;
                            err_d  = 1'b1;
                        end else begin
                            fail_d  = FW'(MAX_FAIL);
                            state_d = LOCKOUT;
                            timer_d = TW'(LOCKOUT_CYC);
                        end
                    end
                end
            end
            OPEN: begin
                if (LOAD) begin
                    combo_d = combo_in;
                    state_d = ENTRY;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                end else if (clear) begin
                    state_d = ENTRY;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                end
            end
            LOCKOUT: begin
                // Leaving on timer==1 keeps alarm high for LOCKOUT_CYC cycles.
                if (timer_q == TW'(1)) begin
                    state_d = ENTRY;
                    timer_d = '0;
                    fail_d  = '0;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = UNPROG;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= UNPROG;
            combo_q <= '0;
            idx_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            mis_q   <= 1'b0;
            prog_q  <= 1'b0;
            err_q   <= 1'b0;
            unl_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            combo_q <= combo_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            mis_q   <= mis_d;
            prog_q  <= prog_d;
            err_q   <= err_d;
            unl_q   <= (state_d == OPEN);
            alarm_q <= (state_d == LOCKOUT);
        end
    end

    assign unlocked   = unl_q;
    assign err        = err_q;
    assign alarm      = alarm_q;
    assign fail_cnt   = fail_q;
    assign digit_idx  = idx_q;
    assign programmed = prog_q;

endmodule

// File: tb/tb_combo_check_param.sv
// Directed plus randomized bench for combo_check_param against a
// queue-based reference model of the entry rules.
module tb_combo_check_param;

    localparam int DIGITS      = 6;
    localparam int WIDTH       = 5;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 16;
    localparam int FW          = $clog2(MAX_FAIL + 1);
    localparam int IW          = $clog2(DIGITS);
    localparam int CW          = DIGITS * WIDTH;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          LOAD = 1'b0;
    logic [CW-1:0] combo_in = '0;
    logic [WIDTH-1:0] digit_in = '0;
    logic          digit_valid = 1'b0;
    logic          clear = 1'b0;
    logic          unlocked, err, alarm, programmed;
    logic [FW-1:0] fail_cnt;
    logic [IW-1:0] digit_idx;

    combo_check_param #(
        .DIGITS(DIGITS), .WIDTH(WIDTH),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD),
        .combo_in(combo_in), .digit_in(digit_in),
        .digit_valid(digit_valid), .clear(clear),
        .unlocked(unlocked), .err(err), .alarm(alarm),
        .fail_cnt(fail_cnt), .digit_idx(digit_idx),
        .programmed(programmed)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_combo [DIGITS];
    logic [WIDTH-1:0] m_q [$];
    bit m_prog, m_open, m_err;
    int m_fails, m_lock;

    localparam logic [CW-1:0] CODE_A =
        {5'b01001, 5'b01001, 5'b00000, 5'b00000, 5'b11101, 5'b11101};
    localparam logic [CW-1:0] WRONG_A =
        {5'b01000, 5'b01001, 5'b00000, 5'b00000, 5'b11101, 5'b11101};
    localparam logic [CW-1:0] CODE_B =
        {5'b11100, 5'b11100, 5'b11010, 5'b11010, 5'b10101, 5'b10101};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DIGITS; k++) m_combo[k] = '0;
        m_q.delete();
        m_prog = 0; m_open = 0; m_err = 0;
        m_fails = 0; m_lock = 0;
    endtask

    task automatic model_load(logic [CW-1:0] c);
        for (int k = 0; k < DIGITS; k++) m_combo[k] = c[k*WIDTH +: WIDTH];
    endtask

    task automatic model_step(bit ld, logic [CW-1:0] c,
                              logic [WIDTH-1:0] d, bit v, bit clr);
        bit ok;
        m_err = 0;
        if (!m_prog) begin
            if (ld) begin
                model_load(c);
                m_prog = 1; m_open = 0; m_fails = 0;
                m_q.delete();
            end
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin
                m_fails = 0;
                m_q.delete();
            end
        end else if (m_open) begin
            if (ld) begin
                model_load(c);
                m_open = 0;
            end else if (clr) begin
                m_open = 0;
            end
        end else if (clr) begin
            m_q.delete();
        end else if (v) begin
            m_q.push_back(d);
            if (m_q.size() == DIGITS) begin
                ok = 1;
                for (int k = 0; k < DIGITS; k++)
                    if (m_q[k] !== m_combo[k]) ok = 0;
                m_q.delete();
                if (ok) begin
                    m_open = 1;
                    m_fails = 0;
                end else begin
                    m_fails++;
                    if (m_fails == MAX_FAIL) m_lock = LOCKOUT_CYC;
                    else m_err = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("unlocked", 32'(unlocked), 32'(m_open));
        chk("err", 32'(err), 32'(m_err));
        chk("alarm", 32'(alarm), 32'(m_lock > 0));
        chk("fail_cnt", 32'(fail_cnt), 32'(m_fails));
        chk("digit_idx", 32'(digit_idx), 32'(m_q.size()));
        chk("programmed", 32'(programmed), 32'(m_prog));
    endtask

    task automatic step(bit ld, logic [CW-1:0] c,
                        logic [WIDTH-1:0] d, bit v, bit clr);
        @(negedge CLK);
        LOAD = ld; combo_in = c; digit_in = d;
        digit_valid = v; clear = clr;
        @(posedge CLK);
        model_step(ld, c, d, v, clr);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, '0, '0, 0, 0);
    endtask

    task automatic enter(logic [CW-1:0] c, int n);
        for (int k = 0; k < n; k++) step(0, '0, c[k*WIDTH +: WIDTH], 1, 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_unl"}, 32'(unlocked), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_alarm"}, 32'(alarm), 0);
        chk({tag, "_fail"}, 32'(fail_cnt), 0);
        chk({tag, "_idx"}, 32'(digit_idx), 0);
        chk({tag, "_prog"}, 32'(programmed), 0);
    endtask

    initial begin
        int cnt;
        logic [CW-1:0] rc;
        logic [WIDTH-1:0] rd;
        model_reset();
        #2;
        check_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // Unprogrammed: digits ignored
        step(0, '0, 5'b11101, 1, 0);
        step(0, '0, 5'b00000, 1, 1);

        // Program and open
        step(1, CODE_A, '0, 0, 0);
        chk("prog_after_load", 32'(programmed), 1);
        enter(CODE_A, 5);
        chk("not_open_yet", 32'(unlocked), 0);
        enter(CODE_A >> (5 * WIDTH), 1);
        chk("open", 32'(unlocked), 1);
        chk("open_fail", 32'(fail_cnt), 0);
        step(0, '0, '0, 0, 1);
        chk("relock", 32'(unlocked), 0);

        // Single failure
        enter(WRONG_A, DIGITS);
        chk("fail1_err", 32'(err), 1);
        chk("fail1_cnt", 32'(fail_cnt), 1);
        chk("fail1_idx", 32'(digit_idx), 0);
        idle();
        chk("err_pulse", 32'(err), 0);

        // Lockout
        enter(WRONG_A, DIGITS);
        chk("fail2_err", 32'(err), 1);
        enter(WRONG_A, DIGITS);
        chk("fail3_noerr", 32'(err), 0);
        chk("fail3_alarm", 32'(alarm), 1);
        chk("fail3_cnt", 32'(fail_cnt), MAX_FAIL);
        cnt = 1;
        for (int n = 0; n < 100 && alarm; n++) begin
            step(0, '0, 5'($urandom), 1, 0);
            if (alarm) cnt++;
        end
        chk("alarm_len", 32'(cnt), LOCKOUT_CYC);
        chk("post_lock_fail", 32'(fail_cnt), 0);
        enter(CODE_A, DIGITS);
        chk("post_lock_open", 32'(unlocked), 1);

        // Clear with simultaneous digit
        step(0, '0, '0, 0, 1);
        enter(CODE_A, 3);
        step(0, '0, 5'b00000, 1, 1);
        chk("clear_idx", 32'(digit_idx), 0);
        enter(CODE_A, DIGITS);
        chk("clear_open", 32'(unlocked), 1);
        chk("clear_fail", 32'(fail_cnt), 0);

        // Reprogram from OPEN, LOAD beats digit_valid
        step(1, CODE_B, 5'b11101, 1, 1);
        chk("reprog_unl", 32'(unlocked), 0);
        enter(CODE_A, DIGITS);
        chk("old_code_err", 32'(err), 1);
        enter(CODE_B, DIGITS);
        chk("new_code_open", 32'(unlocked), 1);

        // Async reset mid-entry
        step(0, '0, '0, 0, 1);
        enter(CODE_B, 4);
        @(negedge CLK);
        LOAD = 0; digit_valid = 0; clear = 0;
        #2 RST_N = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        enter(CODE_B, DIGITS);
        chk("ignored_after_rst", 32'(unlocked), 0);

        // Randomized phase
        rc = {$urandom, $urandom};
        step(1, rc, '0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            if (m_q.size() < DIGITS && $urandom_range(3) != 0)
                rd = m_combo[m_q.size()];
            else
                rd = 5'($urandom);
            rc = {$urandom, $urandom};
            step($urandom_range(29) == 0, rc, rd,
                 $urandom_range(9) < 7, $urandom_range(19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
